processador_multiciclo_n: RTL

Parametrised multicycle processor core: NREG general registers of DATA_W bits, accumulator A, result register G, a four-step controller (T0–T3) and a single shared bus. It extends the 16-bit/8-register core with width and register-count parameters and adds AND, signed set-less-than and conditional move (mvnz). It sits under the board top level, fed instruction/immediate words on DIN and stepped by Run.

---
 rtl/processador_multiciclo_n.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/processador_multiciclo_n.sv
`default_nettype none
// ============================================================================
// Module   : processador_multiciclo_n
// Purpose  : Parametrised multicycle processor core. NREG general registers of
//            DATA_W bits, accumulator A, result register G, a four-step Moore
//            controller (T0..T3) and one shared bus. Supports mv, mvi, add,
//            sub, and, signed slt, conditional move (mvnz) and nop.
// Params   : DATA_W - register/bus/DIN width (>= IR_W)
//            NREG   - number of general registers (power of two, 2..16)
// Ports    : Clock    in   rising-edge clock
//            Resetn   in   asynchronous active-low reset
//            Run      in   start request, sampled only in T0
//            DIN      in   instruction (T0) / immediate (T1 of mvi)
//            Done     out  high during the final step of an instruction
//            BusWires out  current bus value
//            Tstep    out  current step, 0=T0 .. 3=T3
//            Rx_data  out  register addressed by IR Rx field (debug)
//            Ry_data  out  register addressed by IR Ry field (debug)
// Config   : PROC_DEBUG_PORTS_EN - when defined, Rx_data/Ry_data show the
//            addressed registers; otherwise both are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module processador_multiciclo_n #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Run,
  input  logic [DATA_W-1:0] DIN,
  output logic              Done,
  output logic [DATA_W-1:0] BusWires,
  output logic [1:0]        Tstep,
  output logic [DATA_W-1:0] Rx_data,
  output logic [DATA_W-1:0] Ry_data
);

  localparam int RW   = $clog2(NREG);
  localparam int IR_W = 3 + 2 * RW;

  localparam logic [2:0] c_OP_MV   = 3'b000;
  localparam logic [2:0] c_OP_MVI  = 3'b001;
  localparam logic [2:0] c_OP_ADD  = 3'b010;
  localparam logic [2:0] c_OP_SUB  = 3'b011;
  localparam logic [2:0] c_OP_AND  = 3'b100;
  localparam logic [2:0] c_OP_SLT  = 3'b101;
  localparam logic [2:0] c_OP_MVNZ = 3'b110;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } tstep_e;

  tstep_e            state_q, state_d;
  logic [IR_W-1:0]   ir_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] g_q;
  logic [DATA_W-1:0] regs_q [NREG];

  logic [2:0]        w_op;
  logic [RW-1:0]     w_rx;
  logic [RW-1:0]     w_ry;
  logic              w_ir_we;
  logic              w_rx_we;
  logic              w_a_we;
  logic              w_g_we;
  logic [DATA_W-1:0] w_alu;

  assign w_op = ir_q[IR_W-1 -: 3];
  assign w_rx = ir_q[2*RW-1 -: RW];
  assign w_ry = ir_q[RW-1:0];

  assign Tstep = state_q;

  // --------------------------------------------------------------------------
  // Step register
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= T0;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Controller: next step, bus source, write enables and Done. Everything is
  // decoded from the current step and IR; the only data-dependent decision
  // is mvnz, which looks at G to decide whether the move happens.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    Done     = 1'b0;
    BusWires = '0;
    w_ir_we  = 1'b0;
    w_rx_we  = 1'b0;
    w_a_we   = 1'b0;
    w_g_we   = 1'b0;

    case (state_q)
      T0: begin
        if (Run) begin
          w_ir_we = 1'b1;
          state_d = T1;
        end
      end

      T1: begin
        case (w_op)
          c_OP_MV: begin
            BusWires = regs_q[w_ry];
            w_rx_we  = 1'b1;
            Done     = 1'b1;
            state_d  = T0;
          end
          c_OP_MVI: begin
            BusWires = DIN;
            w_rx_we  = 1'b1;
            Done     = 1'b1;
            state_d  = T0;
          end
          c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_SLT: begin
            BusWires = regs_q[w_rx];
            w_a_we   = 1'b1;
            state_d  = T2;
          end
          c_OP_MVNZ: begin
            if (g_q != '0) begin
              BusWires = regs_q[w_ry];
              w_rx_we  = 1'b1;
            end
            Done    = 1'b1;
            state_d = T0;
          end
          default: begin
            // nop: finishes with nothing on the bus
            Done    = 1'b1;
            state_d = T0;
          end
        endcase
      end

      T2: begin
        BusWires = regs_q[w_ry];
        w_g_we   = 1'b1;
        state_d  = T3;
      end

      T3: begin
        BusWires = g_q;
        w_rx_we  = 1'b1;
        Done     = 1'b1;
        state_d  = T0;
      end

      default: begin
        state_d = T0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // ALU: A is the first operand, the bus (Ry in T2) is the second
  // --------------------------------------------------------------------------
  always_comb begin
    w_alu = '0;
    case (w_op)
      c_OP_ADD: w_alu = a_q + BusWires;
      c_OP_SUB: w_alu = a_q - BusWires;
      c_OP_AND: w_alu = a_q & BusWires;
      c_OP_SLT: w_alu = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(BusWires))};
      default:  w_alu = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      ir_q <= '0;
      a_q  <= '0;
      g_q  <= '0;
    end else begin
      if (w_ir_we) begin
        ir_q <= DIN[IR_W-1:0];
      end
      if (w_a_we) begin
        a_q <= BusWires;
      end
      if (w_g_we) begin
        g_q <= w_alu;
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (w_rx_we) begin
      regs_q[w_rx] <= BusWires;
    end
  end

  // --------------------------------------------------------------------------
  // Debug read ports
  // --------------------------------------------------------------------------
`ifdef PROC_DEBUG_PORTS_EN
  assign Rx_data = regs_q[w_rx];
  assign Ry_data = regs_q[w_ry];
`else
  assign Rx_data = '0;
  assign Ry_data = '0;
`endif

endmodule
`default_nettype wire
